// File: rtl/tas_pkg.sv
// Shared types and constants for the temperature averaging system (TAS).
package tas_pkg;

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_BGAP, S_PGAP} ser_state_t;

  localparam logic [7:0]  TAS_HDR_A         = 8'hA5;
  localparam logic [7:0]  TAS_HDR_B         = 8'hC3;
  localparam int unsigned TAS_BYTES_PER_PKT = 5;
  localparam int unsigned TAS_BITS_PER_BYTE = 8;

endpackage

// File: rtl/tas_pkt_serializer.sv
// Serialises one header byte plus four temperature bytes per handshake into the
// gated serial_data/data_ena stream consumed by the TAS deserializer.
module tas_pkt_serializer
  import tas_pkg::*;
#(
  parameter int unsigned BYTE_GAP = 2,
  parameter int unsigned PKT_GAP  = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  logic [7:0]       pkt_header,
  input  logic [31:0]      pkt_temps,
  output logic             serial_data,
  output logic             data_ena,
  output logic             busy,
  output logic             pkt_sent,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int unsigned GAP_MAX = (BYTE_GAP > PKT_GAP) ? BYTE_GAP : PKT_GAP;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);
  localparam int unsigned SH_W    = TAS_BYTES_PER_PKT * TAS_BITS_PER_BYTE;

  localparam logic [GAP_W-1:0] BGAP_LOAD = GAP_W'(BYTE_GAP - 1);
  localparam logic [GAP_W-1:0] PGAP_LOAD = GAP_W'(PKT_GAP - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(TAS_BITS_PER_BYTE - 1);
  localparam logic [2:0]       LAST_BYTE = 3'(TAS_BYTES_PER_PKT - 1);

  ser_state_t        state_q, state_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
  logic              pkt_ready_q, pkt_ready_d;
  logic              busy_q, busy_d;
  logic              data_ena_q, data_ena_d;
  logic              serial_data_q, serial_data_d;
  logic              pkt_sent_q, pkt_sent_d;

  // Outputs are computed for the state being entered, so every output is a flop
  // that already reflects the new state in the first cycle after the edge.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    gap_d         = gap_q;
    pkt_count_d   = pkt_count_q;
    pkt_ready_d   = pkt_ready_q;
    busy_d        = busy_q;
    data_ena_d    = 1'b0;
    serial_data_d = 1'b0;
    pkt_sent_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        pkt_ready_d = 1'b1;
        if (pkt_valid && pkt_ready_q) begin
          shreg_d       = {pkt_temps, pkt_header};
          bit_cnt_d     = '0;
          byte_cnt_d    = '0;
          state_d       = S_SHIFT;
          busy_d        = 1'b1;
          pkt_ready_d   = 1'b0;
          data_ena_d    = 1'b1;
          serial_data_d = pkt_header[0];
        end
      end
      S_SHIFT: begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == LAST_BIT) begin
          if (byte_cnt_q != LAST_BYTE) begin
            state_d = S_BGAP;
            gap_d   = BGAP_LOAD;
          end else begin
            state_d     = S_PGAP;
            gap_d       = PGAP_LOAD;
            pkt_sent_d  = 1'b1;
            pkt_count_d = pkt_count_q + 1'b1;
          end
        end else begin
          data_ena_d    = 1'b1;
          serial_data_d = shreg_q[1];
        end
      end
      S_BGAP: begin
        if (gap_q == '0) begin
          state_d       = S_SHIFT;
          bit_cnt_d     = '0;
          byte_cnt_d    = byte_cnt_q + 3'd1;
          data_ena_d    = 1'b1;
          serial_data_d = shreg_q[0];
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_PGAP: begin
        if (gap_q == '0) begin
          state_d     = S_IDLE;
          busy_d      = 1'b0;
          pkt_ready_d = 1'b1;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      gap_q         <= '0;
      pkt_count_q   <= '0;
      pkt_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      data_ena_q    <= 1'b0;
      serial_data_q <= 1'b0;
      pkt_sent_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_q         <= gap_d;
      pkt_count_q   <= pkt_count_d;
      pkt_ready_q   <= pkt_ready_d;
      busy_q        <= busy_d;
      data_ena_q    <= data_ena_d;
      serial_data_q <= serial_data_d;
      pkt_sent_q    <= pkt_sent_d;
    end
  end

  assign pkt_ready   = pkt_ready_q;
  assign serial_data = serial_data_q;
  assign data_ena    = data_ena_q;
  assign busy        = busy_q;
  assign pkt_sent    = pkt_sent_q;
  assign pkt_count   = pkt_count_q;

endmodule

// File: tb/tb_tas_pkt_serializer.sv
// Bench for tas_pkt_serializer: default-gap and minimum-gap builds checked cycle by
// cycle against a byte/gap framing model of the serial stream.
module tb_tas_pkt_serializer;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        pkt_valid = 1'b0;
  logic [7:0]  pkt_header = '0;
  logic [31:0] pkt_temps = '0;
  logic        sel = 1'b0;

  logic        a_ready, a_dat, a_ena, a_busy, a_sent;
  logic [15:0] a_cnt;
  logic        b_ready, b_dat, b_ena, b_busy, b_sent;
  logic [15:0] b_cnt;

  logic        o_ready, o_dat, o_ena, o_busy, o_sent;
  logic [15:0] o_cnt;

  int checks = 0;
  int failures = 0;
  logic [15:0] cnt_a = '0;
  logic [15:0] cnt_b = '0;
  logic [4:0]  exp_q [$];

  always #10 clk_50 = ~clk_50;

  tas_pkt_serializer #(.BYTE_GAP(2), .PKT_GAP(4), .CNT_W(16)) dut_a (
    .clk_50(clk_50), .reset_n(reset_n), .pkt_valid(pkt_valid && !sel), .pkt_ready(a_ready),
    .pkt_header(pkt_header), .pkt_temps(pkt_temps), .serial_data(a_dat), .data_ena(a_ena),
    .busy(a_busy), .pkt_sent(a_sent), .pkt_count(a_cnt)
  );

  tas_pkt_serializer #(.BYTE_GAP(1), .PKT_GAP(1), .CNT_W(16)) dut_b (
    .clk_50(clk_50), .reset_n(reset_n), .pkt_valid(pkt_valid && sel), .pkt_ready(b_ready),
    .pkt_header(pkt_header), .pkt_temps(pkt_temps), .serial_data(b_dat), .data_ena(b_ena),
    .busy(b_busy), .pkt_sent(b_sent), .pkt_count(b_cnt)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_dat   = sel ? b_dat   : a_dat;
  assign o_ena   = sel ? b_ena   : a_ena;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_sent  = sel ? b_sent  : a_sent;
  assign o_cnt   = sel ? b_cnt   : a_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle {data_ena, serial_data, busy, pkt_sent, pkt_ready} from the cycle after accept.
  task automatic build_model(input logic [7:0] h, input logic [31:0] t, input int bg, input int pg);
    logic [7:0] bytes [5];
    int gaps;
    bytes = '{h, t[7:0], t[15:8], t[23:16], t[31:24]};
    exp_q.delete();
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, bytes[b][i], 1'b1, 1'b0, 1'b0});
      gaps = (b < 4) ? bg : pg;
      for (int g = 0; g < gaps; g++) exp_q.push_back({1'b0, 1'b0, 1'b1, (b == 4 && g == 0), 1'b0});
    end
  endtask

  task automatic send_pkt(input string tag, input logic [7:0] h, input logic [31:0] t,
                          input bit hold, input bit b2b);
    int wait_cyc, bursts;
    logic prev_ena;
    build_model(h, t, sel ? 1 : 2, sel ? 1 : 4);
    pkt_header = h;
    pkt_temps  = t;
    pkt_valid  = 1'b1;
    wait_cyc   = 0;
    while (o_ready !== 1'b1 && wait_cyc < 100) begin
      @(negedge clk_50);
      wait_cyc++;
    end
    if (b2b) chk({tag, "_b2b_wait"}, 32'(wait_cyc), 32'd0);
    else     chk({tag, "_accept"}, 32'(o_ready), 32'd1);
    @(negedge clk_50);
    if (!hold) pkt_valid = 1'b0;
    bursts   = 0;
    prev_ena = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), 32'({o_ena, o_dat, o_busy, o_sent, o_ready}), 32'(exp_q[i]));
      if (o_ena && !prev_ena) bursts++;
      prev_ena = o_ena;
      @(negedge clk_50);
    end
    if (sel) cnt_b++; else cnt_a++;
    chk({tag, "_ready_after"}, 32'({o_ena, o_busy, o_ready}), 32'b001);
    chk({tag, "_bursts"}, 32'(bursts), 32'd5);
    chk({tag, "_count"}, 32'(o_cnt), 32'(sel ? cnt_b : cnt_a));
  endtask

  initial begin
    // Reset with no traffic: everything low during reset, ready right after release.
    repeat (3) begin
      @(negedge clk_50);
      chk("rst_a_outs", 32'({a_ready, a_dat, a_ena, a_busy, a_sent}), 32'd0);
      chk("rst_a_cnt", 32'(a_cnt), 32'd0);
      chk("rst_b_outs", 32'({b_ready, b_dat, b_ena, b_busy, b_sent}), 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk_50);
    chk("rel_a_ready", 32'(a_ready), 32'd1);
    chk("rel_b_ready", 32'(b_ready), 32'd1);

    send_pkt("a5_pkt", 8'hA5, 32'h1E1D1C1B, 1'b0, 1'b0);

    // Held pkt_valid: each packet is taken on the first ready cycle.
    send_pkt("hold0", $urandom_range(0, 1) ? 8'hA5 : 8'hC3, $urandom, 1'b1, 1'b0);
    send_pkt("hold1", 8'($urandom), $urandom, 1'b1, 1'b1);
    send_pkt("hold2", $urandom_range(0, 1) ? 8'hA5 : 8'hC3, $urandom, 1'b0, 1'b1);

    sel = 1'b1;
    send_pkt("min0", 8'hC3, $urandom, 1'b1, 1'b0);
    send_pkt("min1", 8'hA5, $urandom, 1'b0, 1'b1);
    sel = 1'b0;

    // Reset during byte 2, bit 3 drops the partial packet.
    pkt_header = 8'hA5;
    pkt_temps  = $urandom;
    pkt_valid  = 1'b1;
    @(negedge clk_50);
    pkt_valid = 1'b0;
    repeat (23) @(negedge clk_50);
    chk("mid_ena_before", 32'(a_ena), 32'd1);
    reset_n = 1'b0;
    @(negedge clk_50);
    cnt_a = '0;
    cnt_b = '0;
    chk("mid_rst_outs", 32'({a_ready, a_ena, a_busy, a_sent}), 32'd0);
    chk("mid_rst_cnt", 32'(a_cnt), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_50);
    chk("mid_rel_outs", 32'({a_ready, a_ena, a_busy, a_sent}), 32'b1000);
    send_pkt("after_rst", 8'hC3, $urandom, 1'b0, 1'b0);

    // Counter wrap from all-ones.
    force dut_a.pkt_count_q = 16'hFFFF;
    @(negedge clk_50);
    release dut_a.pkt_count_q;
    cnt_a = 16'hFFFF;
    chk("force_cnt", 32'(a_cnt), 32'h0000FFFF);
    send_pkt("wrap", 8'hA5, $urandom, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
